// File: rtl/lram_pkg.sv
// Shared constants and types for the runtime-writable 64x8 LUT-RAM table
// and its write-port arbiter.
package lram_pkg;

   localparam int LRAM_DEPTH  = 64;
   localparam int LRAM_ADDR_W = 6;
   localparam int LRAM_DATA_W = 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } lram_state_e;

   typedef logic [LRAM_ADDR_W-1:0] lram_addr_t;
   typedef logic [LRAM_DATA_W-1:0] lram_data_t;

endpackage

// File: rtl/lram_store.sv
// 64x8 LUT-RAM storage with one synchronous write port and one asynchronous
// read port. Organised as eight 64x1 columns, one per data bit, matching the
// RAM64M8 layout: the write address is port H, the read address is shared by
// ports A..G, and data bit b is the DIb/DOb pair. Column contents start at 0
// and the write clock is not inverted. Storage has no reset; the owner clears
// it by writing every entry.
module lram_store
   import lram_pkg::*;
(
   input  logic       clock,
   input  logic       we,
   input  lram_addr_t waddr,
   input  lram_data_t wdata,
   input  lram_addr_t raddr,
   output lram_data_t rdata
);

   logic [LRAM_DEPTH-1:0] col_q [LRAM_DATA_W];

   for (genvar b = 0; b < LRAM_DATA_W; b++) begin : g_col
      // one 64x1 column per data bit, written on the rising clock edge
      always_ff @(posedge clock) begin
         if (we) begin
            col_q[b][waddr] <= wdata[b];
         end
      end

      assign rdata[b] = col_q[b][raddr];
   end

endmodule

// File: rtl/lram_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of the 64x8 LUT-RAM
// table between NUM_REQ producers, with a hardware clear sequence that
// writes CLEAR_VAL to every entry after reset or on clear_req.
//
// Build option: define LRAM_WR_BYPASS_EN for write-first reads (a read of
// the address being written this cycle returns the new data). Without it
// reads come straight from the RAM and return the old data.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | writing CLEAR_VAL at clr_cnt each cycle, requesters stalled
// ST_RUN   | table valid, one round-robin requester write per cycle
module lram_wr_arbiter
   import lram_pkg::*;
#(
   parameter int                 NUM_REQ   = 4,
   parameter int                 ADDR_W    = LRAM_ADDR_W,
   parameter int                 DATA_W    = LRAM_DATA_W,
   parameter logic [DATA_W-1:0]  CLEAR_VAL = 8'h00,
   localparam int                ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      clear_req,
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      init_done,
   output logic [ID_W-1:0]           grant_id,
   output logic                      wr_fire
);

   lram_state_e       state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic              gnt_found;
   logic [ID_W-1:0]   gnt_idx;
   logic [ID_W-1:0]   cand;
   logic              run_ok;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // base + k wrapped into 0..NUM_REQ-1 (NUM_REQ need not be a power of two)
   function automatic logic [ID_W-1:0] rr_wrap(input logic [ID_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) begin
         s = s - NUM_REQ;
      end
      return ID_W'(s);
   endfunction

   // state register
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   // round-robin search: first valid requester at or above rr_ptr, wrapping
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = rr_wrap(rr_ptr_q, k);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // next-state: clear sweep, clear_req restart, pointer advance on commit
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      rr_ptr_d  = rr_ptr_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == ADDR_W'(LRAM_DEPTH - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (clear_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end else if (gnt_found) begin
               rr_ptr_d = rr_wrap(gnt_idx, 1);
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
         end
      endcase
   end

   // outputs: handshake and RAM write port; everything is held off while
   // reset is low so an abort never leaves a partial write behind
   always_comb begin
      run_ok    = reset && (state_q == ST_RUN) && !clear_req;
      init_done = reset && (state_q == ST_RUN);
      wr_fire   = run_ok && gnt_found;
      grant_id  = wr_fire ? gnt_idx : '0;
      req_ready = wr_fire ? (NUM_REQ'(1) << gnt_idx) : '0;

      mem_we    = reset && ((state_q == ST_CLEAR) || wr_fire);
      if (state_q == ST_CLEAR) begin
         mem_waddr = clr_cnt_q;
         mem_wdata = CLEAR_VAL;
      end else begin
         mem_waddr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
         mem_wdata = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
      end
   end

   lram_store u_store (
      .clock (clock),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (rd_addr),
      .rdata (mem_rdata)
   );

`ifdef LRAM_WR_BYPASS_EN
   // write-first: forward the word being written when the read hits it
   assign rd_data = (mem_we && (mem_waddr == rd_addr)) ? mem_wdata : mem_rdata;
`else
   assign rd_data = mem_rdata;
`endif

endmodule

// File: tb/tb_lram_wr_arbiter.sv
module tb_lram_wr_arbiter;

   localparam int NREQ = 4;

   logic              clock;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*6-1:0] req_addr;
   logic [NREQ*8-1:0] req_data;
   logic              clear_req;
   logic [5:0]        rd_addr;
   logic [7:0]        rd_data;
   logic              init_done;
   logic [1:0]        grant_id;
   logic              wr_fire;

   int   errors = 0;
   int   checks = 0;
   int   exp_q[$];
   bit   sticky = 0;
   int   cnt;
   int   bad;
   logic [1:0] exp_id;
   logic [3:0] exp_oh;

`ifdef LRAM_WR_BYPASS_EN
   localparam logic [7:0] BYP_EXP = 8'h3C;
`else
   localparam logic [7:0] BYP_EXP = 8'h11;
`endif

   lram_wr_arbiter #(.NUM_REQ(NREQ)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .clear_req (clear_req),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .init_done (init_done),
      .grant_id  (grant_id),
      .wr_fire   (wr_fire)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [5:0] a, input logic [7:0] d);
      req_addr[i*6 +: 6] = a;
      req_data[i*8 +: 8] = d;
      req_valid[i]       = 1'b1;
   endtask

   // one clock: accepted one-shot requesters drop valid after their edge
   task automatic step();
      logic [NREQ-1:0] acc;
      @(negedge clock);
      acc = req_valid & req_ready;
      @(posedge clock);
      #1;
      if (!sticky) req_valid = req_valid & ~acc;
   endtask

   task automatic sync();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_init(output int n, output int quiet_bad);
      n = 0;
      quiet_bad = 0;
      while (!init_done && n < 200) begin
         if (req_ready !== '0 || wr_fire !== 1'b0) quiet_bad++;
         step();
         n++;
      end
   endtask

   task automatic rd_chk(input string name, input logic [5:0] a, input logic [7:0] exp);
      rd_addr = a;
      #1;
      chk(name, rd_data, exp);
   endtask

   // scoreboard monitor: every committed write must match the next expected grant
   always @(negedge clock) begin
      if (reset === 1'b1 && wr_fire === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_fire: grant_id=%0d, no grant expected", grant_id);
         end else begin
            exp_id = 2'(exp_q.pop_front());
            if (grant_id !== exp_id) begin
               errors++;
               $display("FAIL grant_order: got %0d, expected %0d", grant_id, exp_id);
            end
         end
         checks++;
         exp_oh = 4'b0001 << grant_id;
         if (req_ready !== exp_oh) begin
            errors++;
            $display("FAIL ready_onehot: got %b, expected %b", req_ready, exp_oh);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
      clear_req = 1'b0; rd_addr = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_init_done", init_done, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_fire", wr_fire, 0);
      chk("rst_grant_id", grant_id, 0);

      // clear after reset
      reset = 1'b1;
      wait_init(cnt, bad);
      chk("clear_cycles", cnt, 64);
      chk("clear_quiet", bad, 0);
      chk("init_done_high", init_done, 1);
      for (int a = 0; a < 64; a++) rd_chk("sweep_zero", 6'(a), 8'h00);
      sync();

      // round-robin with all requesters continuously valid
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
      sticky = 1;
      for (int i = 0; i < NREQ; i++) set_req(i, 6'(20 + i), 8'(8'h10 + i));
      repeat (6) step();
      req_valid = '0;
      sticky = 0;
      chk("rr_drained", exp_q.size(), 0);
      for (int i = 0; i < NREQ; i++) rd_chk("rr_readback", 6'(20 + i), 8'(8'h10 + i));
      sync();

      // sparse requester, then collision after the pointer moved to 3
      exp_q.push_back(2);
      set_req(2, 6'd10, 8'hA5);
      #1;
      chk("sparse_ready", req_ready, 4'b0100);
      step();
      rd_chk("sparse_readback", 6'd10, 8'hA5);
      sync();
      exp_q.push_back(3); exp_q.push_back(0);
      set_req(0, 6'd30, 8'h50);
      set_req(3, 6'd31, 8'h53);
      step();
      step();
      chk("collision_drained", exp_q.size(), 0);
      rd_chk("collision_rd0", 6'd30, 8'h50);
      rd_chk("collision_rd3", 6'd31, 8'h53);
      sync();

      // clear_req while requester 1 is waiting
      exp_q.push_back(1);
      set_req(1, 6'd40, 8'h77);
      clear_req = 1'b1;
      #1;
      chk("clrreq_ready", req_ready, 0);
      chk("clrreq_fire", wr_fire, 0);
      step();
      clear_req = 1'b0;
      chk("clrreq_init_low", init_done, 0);
      wait_init(cnt, bad);
      chk("clrreq_cycles", cnt, 64);
      chk("clrreq_quiet", bad, 0);
      step();
      chk("clrreq_drained", exp_q.size(), 0);
      rd_chk("clrreq_old10", 6'd10, 8'h00);
      rd_chk("clrreq_old20", 6'd20, 8'h00);
      rd_chk("clrreq_new40", 6'd40, 8'h77);
      sync();

      // reset in the middle of a clear sweep
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (30) step();
      reset = 1'b0;
      step();
      step();
      chk("midrst_init", init_done, 0);
      chk("midrst_ready", req_ready, 0);
      chk("midrst_fire", wr_fire, 0);
      reset = 1'b1;
      wait_init(cnt, bad);
      chk("midrst_cycles", cnt, 64);
      chk("midrst_quiet", bad, 0);
      rd_chk("midrst_rd40", 6'd40, 8'h00);
      sync();

      // same-cycle write and read of one address
      exp_q.push_back(0);
      set_req(0, 6'd5, 8'h11);
      step();
      rd_addr = 6'd5;
      exp_q.push_back(0);
      set_req(0, 6'd5, 8'h3C);
      #1;
      chk("bypass_same_cycle", rd_data, BYP_EXP);
      step();
      rd_chk("bypass_after", 6'd5, 8'h3C);
      chk("final_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
